// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: widths, the hardwired zero register index,
// and the register-index / data-word types used by every pipeline register.
package mips_pkg;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 5;
    localparam int REG_COUNT = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam reg_idx_t ZERO_REG = 5'd0;

endpackage

// File: rtl/wb_regfile_if.sv
// Bus between the MEM/WB pipeline register / ID stage and the write-back
// register file. master drives control, data and read indices; slave returns
// read data, the write-back value, its valid flag and the commit counter.
interface wb_regfile_if;
    import mips_pkg::*;

    logic        MemToReg;
    logic        RegWrite;
    word_t       ReadData;
    word_t       ALUResult;
    reg_idx_t    DestinationReg;
    reg_idx_t    ReadReg1;
    reg_idx_t    ReadReg2;
    word_t       ReadData1;
    word_t       ReadData2;
    word_t       WBData;
    logic        WBValid;
    logic [31:0] WriteCount;

    modport master (
        output MemToReg, RegWrite, ReadData, ALUResult, DestinationReg,
               ReadReg1, ReadReg2,
        input  ReadData1, ReadData2, WBData, WBValid, WriteCount
    );

    modport slave (
        input  MemToReg, RegWrite, ReadData, ALUResult, DestinationReg,
               ReadReg1, ReadReg2,
        output ReadData1, ReadData2, WBData, WBValid, WriteCount
    );

endinterface

// File: rtl/wb_select.sv
// Write-back value select: load data when mem_to_reg is set, otherwise the
// ALU result. Purely combinational so the forwarding path can reuse it.
module wb_select
    import mips_pkg::*;
(
    input  logic  mem_to_reg,
    input  word_t read_data,
    input  word_t alu_result,
    output word_t wb_data
);

    assign wb_data = mem_to_reg ? read_data : alu_result;

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage and 32x32 general-purpose register file.
// Register 0 reads as zero and ignores writes. Two asynchronous read ports,
// one synchronous write port, and a count of committed writes.
// Optional macro REGFILE_BYPASS_EN: a read of the register being written in
// the same cycle returns the new value instead of the old contents.
module wb_regfile
    import mips_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    wb_regfile_if.slave  bus
);

    word_t       regs_reg [REG_COUNT];
    logic [31:0] write_count_reg;
    logic [31:0] write_count_next;
    word_t       wb_data;
    logic        wb_valid;
    reg_idx_t    rd_idx [2];

    wb_select u_wb_select (
        .mem_to_reg (bus.MemToReg),
        .read_data  (bus.ReadData),
        .alu_result (bus.ALUResult),
        .wb_data    (wb_data)
    );

    // Writes aimed at register 0 are never valid, so they neither commit nor count.
    assign wb_valid   = bus.RegWrite && (bus.DestinationReg != ZERO_REG);
    assign bus.WBData  = wb_data;
    assign bus.WBValid = wb_valid;

    // Register array: clear everything on reset (dropping that cycle's write), else commit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (wb_valid) begin
            regs_reg[bus.DestinationReg] <= wb_data;
        end
    end

    // Next commit count; wraps naturally at 32 bits.
    always_comb begin
        write_count_next = write_count_reg;
        if (wb_valid) begin
            write_count_next = write_count_reg + 32'd1;
        end
    end

    // Commit counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            write_count_reg <= '0;
        end else begin
            write_count_reg <= write_count_next;
        end
    end

    assign bus.WriteCount = write_count_reg;

    assign rd_idx[0] = bus.ReadReg1;
    assign rd_idx[1] = bus.ReadReg2;

    // One identical asynchronous read port per index.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_read
            word_t data;

            // Read mux: index 0 is forced to zero; optional same-cycle write-through.
            always_comb begin
                data = (rd_idx[gi] == ZERO_REG) ? '0 : regs_reg[rd_idx[gi]];
`ifdef REGFILE_BYPASS_EN
                if (wb_valid && (rd_idx[gi] == bus.DestinationReg)) begin
                    data = wb_data;
                end
`endif
            end
        end
    endgenerate

    assign bus.ReadData1 = g_read[0].data;
    assign bus.ReadData2 = g_read[1].data;

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage and general-purpose register file. Sits at the consuming end of the MEM/WB pipeline register.
- Takes MEM/WB control and data, selects the write-back value, and commits it to the 32x32 register file.
- Serves the two ID-stage read ports and reports the committed value for forwarding.

Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 5, register index width
- REG_COUNT, 32, number of architectural registers (2**ADDR_W)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low
- MemToReg  in  1  from MEM/WB; 1 = write ReadData, 0 = write ALUResult
- RegWrite  in  1  from MEM/WB; write enable
- ReadData  in  DATA_W  memory load data from MEM/WB
- ALUResult  in  DATA_W  ALU result from MEM/WB
- DestinationReg  in  ADDR_W  destination index from MEM/WB
- ReadReg1  in  ADDR_W  ID read port 1 index
- ReadReg2  in  ADDR_W  ID read port 2 index
- ReadData1  out  DATA_W  read port 1 data (combinational)
- ReadData2  out  DATA_W  read port 2 data (combinational)
- WBData  out  DATA_W  current write-back value, combinational, for the forwarding unit
- WBValid  out  1  RegWrite && DestinationReg != 0, combinational
- WriteCount  out  32  registered count of committed writes

Behaviour:
- Write-back select: WBData = MemToReg ? ReadData : ALUResult. Pure mux, no latency.
- Commit on rising clk when rst==1 and WBValid==1: regs[DestinationReg] <= WBData.
- Register 0 is hardwired to zero.
  - Writes to index 0 are dropped.
  - Reads of index 0 return 0.
  - WBValid is 0 for index 0, even when RegWrite=1.
- Reads are asynchronous: ReadDataN = regs[ReadRegN] for N = 1, 2. Data written at edge k is visible after edge k.
- Same-cycle read/write to the same index: governed by REGFILE_BYPASS_EN (see Optional Feature).
- WriteCount:
  - Increments by 1 on each committed write (WBValid==1 and not in reset).
  - Wraps from 0xFFFFFFFF to 0.
  - Writes to register 0 are not counted.
- Reset (rst==0 at a rising edge):
  - All regs[1..31] <= 0 and WriteCount <= 0.
  - Any write presented in that cycle is discarded.
  - Asserting reset mid-stream discards that cycle's write. Register contents go to 0 at that edge.
- Reset values:
  - ReadData1, ReadData2 = 0 after reset for any index.
  - WBData and WBValid follow their inputs; they are combinational and not affected by reset.
- Both read ports may address the same register or the destination register at the same time; there is no conflict.
- No stall or handshake. A write is accepted every cycle.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined:
  - Write-through bypass. If WBValid and ReadRegN == DestinationReg (nonzero), ReadDataN = WBData in the same cycle.
  - This removes the WB->ID hazard; the hazard unit must not stall for that case.
- Undefined:
  - ReadDataN returns the old register contents until the edge; the new value appears the cycle after.
  - The hazard or forwarding logic must cover the WB->ID distance.

Decomposition:
- Shared package (mips_pkg):
  - DATA_W=32, ADDR_W=5, REG_COUNT=32
  - ZERO_REG=5'd0
  - reg_idx_t (ADDR_W-bit) and word_t (DATA_W-bit) typedefs, shared with the ID/EX, EX/MEM and MEM/WB registers
- One natural sub-module: wb_select, the 2:1 MemToReg write-back mux. Reused by the forwarding path.
- Register array and counter stay in wb_regfile.

Test Plan:
- Reset:
  - Stimulus: hold rst=0 for 2 cycles with RegWrite=1, DestinationReg=5, ALUResult=0xDEADBEEF.
  - Response: after reset, ReadReg1=5 gives 0 and WriteCount=0.
- Select and commit:
  - Stimulus: RegWrite=1, MemToReg=0, ALUResult=0x00000011, ReadData=0x22222222, Dest=3; next cycle the same with MemToReg=1 and Dest=4.
  - Response: reg3=0x11, reg4=0x22222222, WriteCount=2.
- Zero register:
  - Stimulus: RegWrite=1, Dest=0, ALUResult=0xFFFFFFFF.
  - Response: WBValid=0, ReadReg1=0 reads 0, WriteCount unchanged.
- Same-cycle hazard:
  - Stimulus: reg7=0x5; write 0xA5A5A5A5 to reg7 while ReadReg2=7.
  - Response: ReadData2=0xA5A5A5A5 in that cycle if REGFILE_BYPASS_EN is defined, else 0x5 in that cycle; 0xA5A5A5A5 the next cycle in both builds.
- RegWrite low:
  - Stimulus: RegWrite=0, Dest=9, ALUResult=0x1234.
  - Response: reg9 unchanged, WBValid=0, WriteCount unchanged.
- Wrap and reset mid-stream:
  - Stimulus: force WriteCount to 0xFFFFFFFF, then commit one write; next, drop rst=0 in the same cycle as a write to reg12.
  - Response: WriteCount=0 after the write; reg12=0 and WriteCount=0 after the reset edge.
